// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core MEM stage
// and an external host port. The core wins by default. A starvation counter
// bounds how long the host can be denied. A lock mode hands the memory to the
// host exclusively while the core is held.
// Optional feature: define DMEM_ARB_STATS_EN to add a saturating stall-cycle counter.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_core_req,
    input  logic                    i_core_we,
    input  logic [ADDR_WIDTH-1:0]   i_core_addr,
    input  logic [DATA_WIDTH-1:0]   i_core_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_core_wmask,
    output logic                    o_core_stall,
    output logic [DATA_WIDTH-1:0]   o_core_rdata,
    output logic                    o_core_rvalid,
    input  logic                    i_ext_valid,
    output logic                    o_ext_ready,
    input  logic                    i_ext_we,
    input  logic [ADDR_WIDTH-1:0]   i_ext_addr,
    input  logic [DATA_WIDTH-1:0]   i_ext_wdata,
    input  logic                    i_ext_lock,
    output logic [DATA_WIDTH-1:0]   o_ext_rdata,
    output logic                    o_ext_rvalid,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wmask,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]             o_stall_cnt
`endif
);

    localparam int                 WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam int                 MASK_W   = DATA_WIDTH / 8;
    localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    typedef enum logic {
        S_SHARED,
        S_LOCK
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CORE,
        SRC_EXT
    } src_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
    src_e                rdSrc_q, rdSrc_d;
    logic                grantCore;
    logic                grantExt;

    // Pick one winner per cycle: core first unless the host has starved or owns the lock
    always_comb begin
        grantExt  = 1'b0;
        grantCore = 1'b0;
        if (state_q == S_LOCK) begin
            grantExt = i_ext_valid;
        end else begin
            grantExt  = i_ext_valid && (!i_core_req || (waitCnt_q == WAIT_MAX));
            grantCore = i_core_req && !grantExt;
        end
    end

    // Drive the memory command from the winner; idle cycles carry no write and no byte enables
    always_comb begin
        o_mem_en     = grantCore || grantExt;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_wmask  = '0;
        o_ext_ready  = grantExt;
        o_core_stall = i_core_req && !grantCore;
        if (grantExt) begin
            o_mem_we    = i_ext_we;
            o_mem_addr  = i_ext_addr;
            o_mem_wdata = i_ext_wdata;
            o_mem_wmask = {MASK_W{1'b1}};
        end else if (grantCore) begin
            o_mem_we    = i_core_we;
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
            o_mem_wmask = i_core_wmask;
        end
    end

    // Next lock state, host wait counter and owner of the read landing next cycle
    always_comb begin
        state_d   = i_ext_lock ? S_LOCK : S_SHARED;
        waitCnt_d = waitCnt_q;
        rdSrc_d   = SRC_NONE;
        if (state_q == S_LOCK || grantExt || !i_ext_valid) begin
            waitCnt_d = '0;
        end else if (waitCnt_q != WAIT_MAX) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
        if (grantExt && !i_ext_we) begin
            rdSrc_d = SRC_EXT;
        end else if (grantCore && !i_core_we) begin
            rdSrc_d = SRC_CORE;
        end
    end

    // State registers; reset also drops any read that was in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_SHARED;
            waitCnt_q <= '0;
            rdSrc_q   <= SRC_NONE;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            rdSrc_q   <= rdSrc_d;
        end
    end

    assign o_core_rvalid = (rdSrc_q == SRC_CORE);
    assign o_ext_rvalid  = (rdSrc_q == SRC_EXT);
    assign o_core_rdata  = (rdSrc_q == SRC_NONE) ? '0 : i_mem_rdata;
    assign o_ext_rdata   = (rdSrc_q == SRC_NONE) ? '0 : i_mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stallCnt_q;

    // Saturating count of cycles the core spent stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt_q <= '0;
        end else if (o_core_stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign o_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level reference model and a behavioural single-port memory.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SL = 4;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          coreReq, coreWe;
    logic [AW-1:0] coreAddr;
    logic [DW-1:0] coreWdata;
    logic [MW-1:0] coreWmask;
    logic          coreStall, coreRvalid;
    logic [DW-1:0] coreRdata;
    logic          extValid, extReady, extWe, extLock, extRvalid;
    logic [AW-1:0] extAddr;
    logic [DW-1:0] extWdata, extRdata;
    logic          memEn, memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata, memRdata;
    logic [MW-1:0] memWmask;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stallCnt;
`endif

    int passCount = 0;
    int checkCount = 0;

    logic [DW-1:0] mem    [1 << AW];
    logic [DW-1:0] refMem [1 << AW];

    bit            modelLocked;
    int            modelWait;
    int            modelPend;
    logic [DW-1:0] modelPendData;
    int            modelStalls;

    bit            expGrantCore, expGrantExt, expStall, expReady, expMemEn, expMemWe;
    bit            expCoreRvalid, expExtRvalid;
    logic [AW-1:0] expMemAddr;
    logic [DW-1:0] expMemWdata, expRdata;
    logic [MW-1:0] expMemWmask;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .i_core_req(coreReq), .i_core_we(coreWe), .i_core_addr(coreAddr),
        .i_core_wdata(coreWdata), .i_core_wmask(coreWmask),
        .o_core_stall(coreStall), .o_core_rdata(coreRdata), .o_core_rvalid(coreRvalid),
        .i_ext_valid(extValid), .o_ext_ready(extReady), .i_ext_we(extWe),
        .i_ext_addr(extAddr), .i_ext_wdata(extWdata), .i_ext_lock(extLock),
        .o_ext_rdata(extRdata), .o_ext_rvalid(extRvalid),
        .o_mem_en(memEn), .o_mem_we(memWe), .o_mem_addr(memAddr),
        .o_mem_wdata(memWdata), .o_mem_wmask(memWmask), .i_mem_rdata(memRdata)
`ifdef DMEM_ARB_STATS_EN
        , .o_stall_cnt(stallCnt)
`endif
    );

    function automatic logic [DW-1:0] expandMask(input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int b = 0; b < MW; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    function automatic logic [DW-1:0] initWord(input int i);
        if (i == 'h010) return 32'hDEADBEEF;
        return (32'(i) * 32'h0001_0003) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural single-port memory with one cycle of read latency
    always @(posedge clk) begin
        if (memEn && memWe)
            mem[memAddr] <= (mem[memAddr] & ~expandMask(memWmask)) | (memWdata & expandMask(memWmask));
        if (memEn && !memWe)
            memRdata <= mem[memAddr];
    end

    // Reference model: who should win this cycle given the current inputs and model state
    task automatic computeExpected();
        if (modelLocked) begin
            expGrantExt  = extValid;
            expGrantCore = 1'b0;
        end else begin
            expGrantExt  = extValid && (!coreReq || modelWait >= SL);
            expGrantCore = coreReq && !expGrantExt;
        end
        expStall    = coreReq && !expGrantCore;
        expReady    = expGrantExt;
        expMemEn    = expGrantExt || expGrantCore;
        expMemWe    = expGrantExt ? extWe : (expGrantCore ? coreWe : 1'b0);
        expMemAddr  = expGrantExt ? extAddr : coreAddr;
        expMemWdata = expGrantExt ? extWdata : coreWdata;
        expMemWmask = expGrantExt ? {MW{1'b1}} : (expGrantCore ? coreWmask : '0);
        expCoreRvalid = (modelPend == 1);
        expExtRvalid  = (modelPend == 2);
        expRdata      = (modelPend != 0) ? modelPendData : '0;
    endtask

    task automatic modelReset();
        modelLocked = 1'b0;
        modelWait   = 0;
        modelPend   = 0;
        modelStalls = 0;
    endtask

    // Reference model: commit the transaction decided this cycle
    task automatic advanceModel();
        if (!rst) begin
            modelReset();
        end else begin
            computeExpected();
            if (expMemEn && !expMemWe) begin
                modelPend     = expGrantExt ? 2 : 1;
                modelPendData = refMem[expMemAddr];
            end else begin
                modelPend = 0;
            end
            if (expMemEn && expMemWe)
                refMem[expMemAddr] = (refMem[expMemAddr] & ~expandMask(expMemWmask))
                                   | (expMemWdata & expandMask(expMemWmask));
            if (modelLocked || expGrantExt || !extValid) modelWait = 0;
            else if (modelWait < SL) modelWait++;
            if (expStall && modelStalls < 65535) modelStalls++;
            modelLocked = extLock;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        advanceModel();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        coreReq = 0; coreWe = 0; coreAddr = '0; coreWdata = '0; coreWmask = '0;
        extValid = 0; extWe = 0; extAddr = '0; extWdata = '0; extLock = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        #1;
        checkCount++;
        if (coreRvalid !== 1'b0 || extRvalid !== 1'b0) $display("[TB] FAIL reset_rvalid: got core=%b ext=%b, expected 0/0", coreRvalid, extRvalid);
        else passCount++;
        checkCount++;
        if (coreRdata !== '0 || extRdata !== '0) $display("[TB] FAIL reset_rdata: got core=%h ext=%h, expected 0", coreRdata, extRdata);
        else passCount++;
        checkCount++;
        if (memEn !== 1'b0 || memWmask !== '0) $display("[TB] FAIL reset_mem_idle: got en=%b wmask=%h, expected 0/0", memEn, memWmask);
        else passCount++;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_core_read();
        idleInputs();
        coreReq = 1; coreAddr = 10'h010;
        #1; computeExpected();
        checkCount++;
        if (coreStall !== 1'b0 || memEn !== 1'b1 || memAddr !== 10'h010) $display("[TB] FAIL core_read_cmd: got stall=%b en=%b addr=%h, expected 0/1/010", coreStall, memEn, memAddr);
        else passCount++;
        tick();
        idleInputs();
        #1;
        checkCount++;
        if (coreRvalid !== 1'b1 || coreRdata !== 32'hDEADBEEF) $display("[TB] FAIL core_read_data: got v=%b d=%h, expected 1/deadbeef", coreRvalid, coreRdata);
        else passCount++;
        checkCount++;
        if (extRvalid !== 1'b0) $display("[TB] FAIL core_read_ext_rvalid: got %b, expected 0", extRvalid);
        else passCount++;
        tick();
    endtask

    task automatic test_alternating();
        idleInputs();
        coreReq = 1; coreAddr = 10'h001;
        #1;
        tick();
        idleInputs();
        extValid = 1; extAddr = 10'h002;
        #1;
        checkCount++;
        if (coreRvalid !== 1'b1 || extRvalid !== 1'b0 || coreRdata !== initWord(1)) $display("[TB] FAIL alt_core_return: got cv=%b ev=%b d=%h, expected 1/0/%h", coreRvalid, extRvalid, coreRdata, initWord(1));
        else passCount++;
        checkCount++;
        if (extReady !== 1'b1) $display("[TB] FAIL alt_ext_ready: got %b, expected 1", extReady);
        else passCount++;
        tick();
        idleInputs();
        #1;
        checkCount++;
        if (extRvalid !== 1'b1 || coreRvalid !== 1'b0 || extRdata !== initWord(2)) $display("[TB] FAIL alt_ext_return: got ev=%b cv=%b d=%h, expected 1/0/%h", extRvalid, coreRvalid, extRdata, initWord(2));
        else passCount++;
        tick();
    endtask

    task automatic test_contention();
        for (int c = 0; c < 6; c++) begin
            idleInputs();
            coreReq = 1; coreAddr = AW'(10'h100 + c);
            extValid = 1; extAddr = AW'(10'h200 + c);
            #1; computeExpected();
            checkCount++;
            if (coreStall !== (c == 4) || extReady !== (c == 4)) $display("[TB] FAIL contention_c%0d: got stall=%b ready=%b, expected %b/%b", c, coreStall, extReady, (c == 4), (c == 4));
            else passCount++;
            checkCount++;
            if (extRvalid !== (c == 5) || coreRvalid !== (c >= 1 && c != 5) || coreRdata !== expRdata) $display("[TB] FAIL contention_ret_c%0d: got ev=%b cv=%b d=%h, expected %b/%b/%h", c, extRvalid, coreRvalid, coreRdata, (c == 5), (c >= 1 && c != 5), expRdata);
            else passCount++;
            tick();
        end
        idleInputs();
        tick();
    endtask

    task automatic test_lock();
        idleInputs();
        coreReq = 1; coreAddr = 10'h030; extLock = 1;
        #1;
        checkCount++;
        if (coreStall !== 1'b0) $display("[TB] FAIL lock_assert_cycle: got stall=%b, expected 0", coreStall);
        else passCount++;
        tick();
        extValid = 1; extWe = 1; extAddr = 10'h3FF; extWdata = 32'h0000_0055;
        #1;
        checkCount++;
        if (coreStall !== 1'b1 || extReady !== 1'b1) $display("[TB] FAIL lock_host_owns: got stall=%b ready=%b, expected 1/1", coreStall, extReady);
        else passCount++;
        checkCount++;
        if (memWe !== 1'b1 || memAddr !== 10'h3FF || memWdata !== 32'h55 || memWmask !== 4'hF) $display("[TB] FAIL lock_host_write: got we=%b a=%h d=%h m=%h, expected 1/3ff/55/f", memWe, memAddr, memWdata, memWmask);
        else passCount++;
        checkCount++;
        if (coreRvalid !== 1'b1 || coreRdata !== initWord('h030)) $display("[TB] FAIL lock_pending_read: got v=%b d=%h, expected 1/%h", coreRvalid, coreRdata, initWord('h030));
        else passCount++;
        tick();
        idleInputs();
        coreReq = 1; coreAddr = 10'h3FF;
        #1;
        checkCount++;
        if (coreStall !== 1'b1) $display("[TB] FAIL lock_release_cycle: got stall=%b, expected 1", coreStall);
        else passCount++;
        tick();
        #1;
        checkCount++;
        if (coreStall !== 1'b0 || memAddr !== 10'h3FF) $display("[TB] FAIL lock_core_resume: got stall=%b addr=%h, expected 0/3ff", coreStall, memAddr);
        else passCount++;
        tick();
        idleInputs();
        #1;
        checkCount++;
        if (coreRvalid !== 1'b1 || coreRdata !== 32'h55) $display("[TB] FAIL lock_readback: got v=%b d=%h, expected 1/55", coreRvalid, coreRdata);
        else passCount++;
        tick();
    endtask

    task automatic test_reset_mid_read();
        idleInputs();
        coreReq = 1; coreAddr = 10'h020; extLock = 1;
        #1;
        tick();
        rst = 0;
        idleInputs();
        modelReset();
        #1;
        checkCount++;
        if (coreRvalid !== 1'b0 || coreRdata !== '0) $display("[TB] FAIL midread_in_reset: got v=%b d=%h, expected 0/0", coreRvalid, coreRdata);
        else passCount++;
        tick();
        rst = 1;
        coreReq = 1; coreAddr = 10'h021; extValid = 1; extAddr = 10'h022;
        #1;
        checkCount++;
        if (coreRvalid !== 1'b0) $display("[TB] FAIL midread_after_release: got rvalid=%b, expected 0", coreRvalid);
        else passCount++;
        checkCount++;
        if (coreStall !== 1'b0 || extReady !== 1'b0) $display("[TB] FAIL midread_shared_state: got stall=%b ready=%b, expected 0/0", coreStall, extReady);
        else passCount++;
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_random();
        bit prevStall = 0;
        for (int n = 0; n < 400; n++) begin
            if (!prevStall) begin
                coreReq   = ($urandom_range(0, 3) != 0);
                coreWe    = $urandom_range(0, 1);
                coreAddr  = AW'($urandom_range(0, 15));
                coreWdata = $urandom;
                coreWmask = MW'($urandom);
            end
            extValid = ($urandom_range(0, 2) != 0);
            extWe    = $urandom_range(0, 1);
            extAddr  = AW'($urandom_range(0, 15));
            extWdata = $urandom;
            if ($urandom_range(0, 9) == 0) extLock = !extLock;
            #1; computeExpected();
            prevStall = expStall;
            checkCount++;
            if (coreStall !== expStall || extReady !== expReady) $display("[TB] FAIL rnd_grant n=%0d: got stall=%b ready=%b, expected %b/%b", n, coreStall, extReady, expStall, expReady);
            else passCount++;
            checkCount++;
            if (memEn !== expMemEn || memWe !== expMemWe || memWmask !== expMemWmask) $display("[TB] FAIL rnd_cmd n=%0d: got en=%b we=%b m=%h, expected %b/%b/%h", n, memEn, memWe, memWmask, expMemEn, expMemWe, expMemWmask);
            else passCount++;
            if (expMemEn) begin
                checkCount++;
                if (memAddr !== expMemAddr || memWdata !== expMemWdata) $display("[TB] FAIL rnd_mux n=%0d: got a=%h d=%h, expected %h/%h", n, memAddr, memWdata, expMemAddr, expMemWdata);
                else passCount++;
            end
            checkCount++;
            if (coreRvalid !== expCoreRvalid || extRvalid !== expExtRvalid) $display("[TB] FAIL rnd_rvalid n=%0d: got c=%b e=%b, expected %b/%b", n, coreRvalid, extRvalid, expCoreRvalid, expExtRvalid);
            else passCount++;
            checkCount++;
            if (coreRdata !== expRdata || extRdata !== expRdata) $display("[TB] FAIL rnd_rdata n=%0d: got c=%h e=%h, expected %h", n, coreRdata, extRdata, expRdata);
            else passCount++;
            tick();
        end
`ifdef DMEM_ARB_STATS_EN
        #1;
        checkCount++;
        if (stallCnt !== 16'(modelStalls)) $display("[TB] FAIL stall_count: got %0d, expected %0d", stallCnt, modelStalls);
        else passCount++;
`endif
        idleInputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = initWord(i);
            refMem[i] = initWord(i);
        end
        memRdata = '0;
        rst = 0;
        modelReset();
        idleInputs();
        @(negedge clk);
        $display("[TB] starting dmem_arbiter checks");
        test_reset();
        test_core_read();
        test_alternating();
        test_contention();
        test_lock();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core MEM stage and an external host port (program load, debug, Wishbone bridge).
- Core has default priority. A starvation counter bounds host wait. A lock mode gives the host exclusive access while the core is held.
- Drives the memory command bus. Issues the MEM-stage stall. Routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 10, word address width.
- STARVE_LIMIT, 4, number of consecutive denied host cycles after which the host beats a core request; must be >= 1.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous active-low reset.
- i_core_req  in  1  MEM-stage access request.
- i_core_we  in  1  1 = write, 0 = read.
- i_core_addr  in  ADDR_WIDTH  core word address.
- i_core_wdata  in  DATA_WIDTH  core write data.
- i_core_wmask  in  DATA_WIDTH/8  core byte enables.
- o_core_stall  out  1  hold the MEM/WB boundary.
- o_core_rdata  out  DATA_WIDTH  read data returned to the core.
- o_core_rvalid  out  1  core read data valid.
- i_ext_valid  in  1  host request valid.
- o_ext_ready  out  1  host request accepted this cycle.
- i_ext_we  in  1  host write.
- i_ext_addr  in  ADDR_WIDTH  host address.
- i_ext_wdata  in  DATA_WIDTH  host write data; full word, mask all ones.
- i_ext_lock  in  1  host requests exclusive ownership.
- o_ext_rdata  out  DATA_WIDTH  read data returned to the host.
- o_ext_rvalid  out  1  host read data valid.
- o_mem_en, o_mem_we  out  1 each  memory command enable and write enable.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_wdata  out  DATA_WIDTH  memory write data.
- o_mem_wmask  out  DATA_WIDTH/8  memory byte enables.
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after a read command.

Behaviour:
- FSM states:
  - S_SHARED (reset state): core has priority, host is subject to the starvation counter.
  - S_LOCK: host owns the memory exclusively.
- S_SHARED -> S_LOCK on a clock edge where i_ext_lock = 1. S_LOCK -> S_SHARED on a clock edge where i_ext_lock = 0. The lock takes effect the cycle after it is sampled, so a core request in the assertion cycle is still served under S_SHARED rules.
- Grant is combinational, one winner per cycle:
  - S_SHARED: grant_ext = i_ext_valid && (!i_core_req || wait_cnt == STARVE_LIMIT); grant_core = i_core_req && !grant_ext.
  - S_LOCK: grant_ext = i_ext_valid; grant_core = 0.
- o_ext_ready = grant_ext. o_core_stall = i_core_req && !grant_core.
- Memory command:
  - o_mem_en = grant_core || grant_ext.
  - o_mem_addr, o_mem_we, o_mem_wdata and o_mem_wmask are muxed from the winner.
  - When nothing is granted: o_mem_we = 0 and o_mem_wmask = 0.
- wait_cnt, width $clog2(STARVE_LIMIT+1):
  - Cleared on grant_ext, or when i_ext_valid = 0.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - Held at 0 in S_LOCK.
- Read return:
  - The registered owner flag rd_src (none/core/ext) is set on each granted read and cleared otherwise.
  - In the following cycle, o_core_rvalid = (rd_src == core) and o_ext_rvalid = (rd_src == ext).
  - o_core_rdata and o_ext_rdata are both driven by i_mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating requesters must tag each return correctly.
- A stalled core request must be held stable by the pipeline. The arbiter does not latch request contents.
- Reset (rst = 0, asynchronous):
  - State S_SHARED; wait_cnt = 0; rd_src = none.
  - o_core_rvalid = 0, o_ext_rvalid = 0, o_core_rdata = 0, o_ext_rdata = 0 (gated while rd_src = none).
  - A read in flight when reset asserts is dropped: no rvalid after reset release.
- Lock asserted while the core is mid-stall: the core stays stalled until the lock releases. A pending core read granted before the lock still returns its data.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds output o_stall_cnt (16 bits), a saturating count of cycles with o_core_stall = 1. Cleared by reset only.
- Undefined: the port and the counter do not exist. No other behaviour changes.

Test Plan:
- Core read only: core_req = 1, we = 0, addr = 0x010, mem returns 0xDEADBEEF -> stall = 0; core_rvalid = 1 next cycle with rdata 0xDEADBEEF; ext_rvalid = 0.
- Contention, STARVE_LIMIT = 4, core_req and ext_valid held high -> core granted cycles 0-3; ext_ready = 1 and core_stall = 1 at cycle 4; core granted again at cycle 5.
- Alternating reads: cycle 0 core read of 0x001, cycle 1 host read of 0x002 (core idle) -> core_rvalid in cycle 1 and ext_rvalid in cycle 2, each with its own data.
- Lock: ext_lock = 1 while core_req = 1 -> core granted in the assertion cycle, stalled afterwards; host write 0x0000_0055 to 0x3FF has wmask = all ones; core resumes the cycle after lock drops.
- Reset mid-read: assert rst low the cycle after a granted core read -> o_core_rvalid stays 0 and the FSM is back in S_SHARED.
- With DMEM_ARB_STATS_EN, 6 stall cycles -> o_stall_cnt = 6; forced stall of 70000 cycles -> o_stall_cnt = 0xFFFF.
